// File: rtl/shared_pkg.sv
// Types and widths shared between the synchronous FIFO and its read-side engine.
package shared_pkg;

    localparam int FIFO_WIDTH = 16;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ACTIVE,
        RD_HALT
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_buf.sv
// Two-entry circular output buffer that absorbs the FIFO's one-cycle read latency.
module fifo_rd_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [2];
    logic             hd;
    logic             wr_idx;

    // The write slot sits occ entries past the head, modulo 2.
    assign wr_idx    = hd ^ occ[0];
    assign head_data = mem[hd];

    // NOTE: the two data entries are reset along with the pointers so the
    // head output reads zero out of reset instead of X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            hd     <= 1'b0;
            occ    <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments here, so every statement below
            // sees the pre-edge occ/hd and a same-cycle write and pop both
            // resolve against the old head.
            if (wr) begin
                mem[wr_idx] <= wdata;
            end
            if (pop) begin
                hd <= ~hd;
            end
            occ <= occ + {1'b0, wr} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side engine: drains the FIFO into a valid/ready stream, counts delivered
// words and halts reads after a FIFO underflow until the error is cleared.
module fifo_rd_stream #(
    parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clr_err,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  underflow_err
);

    import shared_pkg::*;

    rd_state_e  state;
    logic       inflight;
    logic [1:0] occ;
    logic       pop;
    logic [2:0] pending;

    fifo_rd_buf #(
        .WIDTH (FIFO_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (inflight),
        .wdata     (fifo_data_out),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data)
    );

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;

    // Occupancy after this edge; doubles as the room check for a new read.
    assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    // Gated by rst_n so the FIFO is never popped while this engine is held in reset.
    assign fifo_rd_en = rst_n && enable && !fifo_empty && (state != RD_HALT)
                        && (pending < 3'd2);

    assign underflow_err = (state == RD_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RD_IDLE;
            inflight <= 1'b0;
            rd_count <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) begin
                rd_count <= rd_count + 1'b1;
            end

            if (fifo_underflow) begin
                state <= RD_HALT;
            end else begin
                case (state)
                    RD_IDLE:   if (fifo_rd_en) state <= RD_ACTIVE;
                    RD_ACTIVE: if (pending == 3'd0 && !fifo_rd_en) state <= RD_IDLE;
                    RD_HALT:   if (clr_err) state <= RD_IDLE;
                    default:   state <= RD_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream against a small behavioural FIFO model.
module tb_fifo_rd_stream;

    import shared_pkg::*;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          clr_err = 1'b0;
    logic          fifo_underflow = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_empty;
    logic [W-1:0]  fifo_data_out = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic [CW-1:0] rd_count;
    logic          underflow_err;

    fifo_rd_stream #(
        .FIFO_WIDTH (W),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .clr_err        (clr_err),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .rd_count       (rd_count),
        .underflow_err  (underflow_err)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered read data, one push port driven by the bench.
    logic [W-1:0] fmem [32];
    logic [4:0]   wp = '0;
    logic [4:0]   rp = '0;
    logic [5:0]   fcnt = '0;
    logic         push = 1'b0;
    logic [W-1:0] push_data = '0;
    logic         fpop;

    assign fifo_empty = (fcnt == 6'd0);
    assign fpop       = fifo_rd_en && (fcnt != 6'd0);

    always @(posedge clk) begin
        if (push) begin
            fmem[wp] <= push_data;
            wp       <= wp + 5'd1;
        end
        if (fpop) begin
            fifo_data_out <= fmem[rp];
            rp            <= rp + 5'd1;
        end
        fcnt <= fcnt + 6'(push) - 6'(fpop);
    end

    // Stream monitor: read requests, illegal reads and every delivered word.
    int           n_rd = 0;
    int           n_bad_rd = 0;
    int           n_got = 0;
    logic [W-1:0] got [256];

    always @(posedge clk) begin
        if (fifo_rd_en) n_rd <= n_rd + 1;
        if (fifo_rd_en && fifo_empty) n_bad_rd <= n_bad_rd + 1;
        if (m_valid && m_ready) begin
            got[n_got[7:0]] <= m_data;
            n_got           <= n_got + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_words(input logic [W-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            push      = 1'b1;
            push_data = first + W'(i);
        end
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic wait_got(input int target, input int budget, input string name);
        int k = 0;
        while (n_got < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_timeout"}, 32'(n_got >= target), 32'd1);
    endtask

    typedef struct {
        logic          en;
        logic          rdy;
        logic          exp_rd_en;
        logic          exp_valid;
        logic [W-1:0]  exp_data;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int base_rd;

        // Streaming: first read at row 0, first word two cycles later.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 4'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 4'd1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 4'd2};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0004, 4'd3};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0005, 4'd4};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd5};

        // Reset values.
        #12;
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_count", 32'(rd_count), 32'd0);
        check("rst_err", 32'(underflow_err), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;

        push_words(16'h0001, 5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            enable  = vecs[i].en;
            m_ready = vecs[i].rdy;
            #1;
            check($sformatf("stream_rd_en[%0d]", i), 32'(fifo_rd_en), 32'(vecs[i].exp_rd_en));
            check($sformatf("stream_valid[%0d]", i), 32'(m_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("stream_data[%0d]", i), 32'(m_data), 32'(vecs[i].exp_data));
            end
            check($sformatf("stream_count[%0d]", i), 32'(rd_count), 32'(vecs[i].exp_cnt));
        end
        check("stream_idle", 32'(dut.state), 32'(RD_IDLE));

        // Backpressure: six words waiting, consumer stalled for ten cycles.
        enable  = 1'b0;
        m_ready = 1'b0;
        push_words(16'h0011, 6);
        base    = n_got;
        base_rd = n_rd;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            enable = 1'b1;
            #1;
            if (i >= 2) begin
                check($sformatf("bp_valid[%0d]", i), 32'(m_valid), 32'd1);
                check($sformatf("bp_data[%0d]", i), 32'(m_data), 32'h0011);
            end
        end
        check("bp_reads", 32'(n_rd - base_rd), 32'd2);
        m_ready = 1'b1;
        wait_got(base + 6, 40, "bp_drain");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_order[%0d]", i), 32'(got[8'(base + i)]), 32'(16'h0011 + i));
        end
        check("bp_count", 32'(rd_count), 32'd11);

        // Alternating consumer with the FIFO refilled every cycle.
        base = n_got;
        fork
            push_words(16'h0021, 8);
            begin
                repeat (24) begin
                    @(negedge clk);
                    m_ready = ~m_ready;
                end
            end
        join
        m_ready = 1'b1;
        wait_got(base + 8, 30, "alt_drain");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("alt_order[%0d]", i), 32'(got[8'(base + i)]), 32'(16'h0021 + i));
        end
        check("alt_count", 32'(rd_count), 32'd3);
        check("alt_total", 32'(n_got - base), 32'd8);

        // Underflow: fill the buffer, flag underflow, drain, then clear.
        enable  = 1'b0;
        m_ready = 1'b0;
        push_words(16'h0051, 3);
        base = n_got;
        @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        fifo_underflow = 1'b1;
        @(negedge clk);
        fifo_underflow = 1'b0;
        #1;
        check("uf_err_set", 32'(underflow_err), 32'd1);
        check("uf_rd_blocked", 32'(fifo_rd_en), 32'd0);
        base_rd = n_rd;
        m_ready = 1'b1;
        wait_got(base + 2, 20, "uf_drain");
        repeat (3) @(negedge clk);
        #1;
        check("uf_no_reads", 32'(n_rd - base_rd), 32'd0);
        check("uf_err_sticky", 32'(underflow_err), 32'd1);
        check("uf_word0", 32'(got[8'(base)]), 32'h0051);
        check("uf_word1", 32'(got[8'(base + 1)]), 32'h0052);
        @(negedge clk);
        clr_err        = 1'b1;
        fifo_underflow = 1'b1;
        @(negedge clk);
        clr_err        = 1'b0;
        fifo_underflow = 1'b0;
        #1;
        check("uf_halt_wins", 32'(underflow_err), 32'd1);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        #1;
        check("uf_cleared", 32'(underflow_err), 32'd0);
        check("uf_resume_rd", 32'(fifo_rd_en), 32'd1);
        wait_got(base + 3, 20, "uf_resume");
        check("uf_word2", 32'(got[8'(base + 2)]), 32'h0053);
        check("uf_count", 32'(rd_count), 32'd6);

        // Reset with two words buffered: they are discarded.
        enable  = 1'b0;
        m_ready = 1'b0;
        push_words(16'h0041, 6);
        @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_data", 32'(m_data), 32'd0);
        check("mid_rst_count", 32'(rd_count), 32'd0);
        check("mid_rst_err", 32'(underflow_err), 32'd0);
        base = n_got;
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        wait_got(base + 4, 30, "mid_rst_drain");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mid_rst_order[%0d]", i), 32'(got[8'(base + i)]), 32'(16'h0043 + i));
        end
        check("mid_rst_count_after", 32'(rd_count), 32'd4);

        // Counter wrap: 17 deliveries on a 4-bit counter.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base  = n_got;
        push_words(16'h0061, 17);
        wait_got(base + 17, 60, "wrap_drain");
        @(negedge clk);
        check("wrap_count", 32'(rd_count), 32'd1);
        check("wrap_last", 32'(got[8'(base + 16)]), 32'h0071);

        check("rd_while_empty", 32'(n_bad_rd), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
